// File: rtl/alu_seq_pkg.sv
// Shared operator codes, mode constants and FSM state type for the sequenced ALU core.
package alu_seq_pkg;

    localparam logic MODE_LOGIC  = 1'b0;
    localparam logic MODE_MULDIV = 1'b1;

    localparam logic [5:0] OP_AND = 6'd0;
    localparam logic [5:0] OP_OR  = 6'd1;
    localparam logic [5:0] OP_XOR = 6'd2;
    localparam logic [5:0] OP_NOT = 6'd3;
    localparam logic [5:0] OP_ADD = 6'd4;
    localparam logic [5:0] OP_SUB = 6'd5;
    localparam logic [5:0] OP_SHL = 6'd6;
    localparam logic [5:0] OP_SHR = 6'd7;

    localparam logic [5:0] OP_MUL = 6'd0;
    localparam logic [5:0] OP_DIV = 6'd1;
    localparam logic [5:0] OP_MOD = 6'd2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative engine: W-step shift-add multiplier and restoring divider sharing one acc/lo pair.
// Result outputs show the post-step value, so they are final in the cycle done is high.
module seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 5
) (
    input  logic           Clk,
    input  logic           reset,
    input  logic           start,
    input  logic [5:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder
);
    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     acc_q, lo_q, a_q, b_q;
    logic             is_mul_q;

    logic [W:0]   sum, shifted;
    logic [W-1:0] diff, acc_nx, lo_nx;
    logic         ge;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, (lo_q[0] ? a_q : '0)};
        shifted = {acc_q, lo_q[W-1]};
        ge      = shifted >= {1'b0, b_q};
        diff    = shifted[W-1:0] - b_q;
        if (is_mul_q) begin
            acc_nx = sum[W:1];
            lo_nx  = {sum[0], lo_q[W-1:1]};
        end else begin
            // remainder stays below b, so W bits always hold it
            acc_nx = ge ? diff : shifted[W-1:0];
            lo_nx  = {lo_q[W-2:0], ge};
        end
    end

    assign done      = (cnt_q == CNT_W'(1));
    assign product   = {acc_nx, lo_nx};
    assign quotient  = lo_nx;
    assign remainder = acc_nx;

    always_ff @(posedge Clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            is_mul_q <= 1'b0;
        end else if (start) begin
            cnt_q    <= CNT_W'(W);
            acc_q    <= '0;
            lo_q     <= (op == OP_MUL) ? b : a;
            a_q      <= a;
            b_q      <= b;
            is_mul_q <= (op == OP_MUL);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            acc_q <= acc_nx;
            lo_q  <= lo_nx;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked two-mode ALU: single-cycle logic/arith, iterative mul/div/mod, registered flags.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int unsigned W     = 5,
    parameter int unsigned OUT_W = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [W-1:0]     number1,
    input  logic [W-1:0]     number2,
    input  logic [5:0]       operator_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] output_num,
    output logic             balanceBit,
    output logic             equalityBit,
    output logic             error,
    output logic             busy
);
    localparam int unsigned SH_W = $clog2(W);

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [OUT_W-1:0] num_q, num_d;
    logic             err_q, err_d, eq_q, eq_d, bal_q;

    logic [W:0]       add_res, sub_res;
    logic [W-1:0]     not_res, shl_res, shr_res;
    logic [OUT_W-1:0] logic_res;
    logic             illegal, div_zero, md_start, md_done;
    logic [2*W-1:0]   md_product;
    logic [W-1:0]     md_quotient, md_remainder;

    seq_muldiv #(.W(W)) u_muldiv (
        .Clk       (Clk),
        .reset     (reset),
        .start     (md_start),
        .op        (operator_mode),
        .a         (number1),
        .b         (number2),
        .done      (md_done),
        .product   (md_product),
        .quotient  (md_quotient),
        .remainder (md_remainder)
    );

    always_comb begin
        add_res = {1'b0, number1} + {1'b0, number2};
        // bit W of the wider difference is the borrow
        sub_res = {1'b0, number1} - {1'b0, number2};
        not_res = ~number1;
        shl_res = number1 << number2[SH_W-1:0];
        shr_res = number1 >> number2[SH_W-1:0];
        case (operator_mode)
            OP_AND:  logic_res = OUT_W'(number1 & number2);
            OP_OR:   logic_res = OUT_W'(number1 | number2);
            OP_XOR:  logic_res = OUT_W'(number1 ^ number2);
            OP_NOT:  logic_res = OUT_W'(not_res);
            OP_ADD:  logic_res = OUT_W'(add_res);
            OP_SUB:  logic_res = OUT_W'(sub_res);
            OP_SHL:  logic_res = OUT_W'(shl_res);
            OP_SHR:  logic_res = OUT_W'(shr_res);
            default: logic_res = '0;
        endcase
        illegal  = (mode == MODE_MULDIV) ? (operator_mode > OP_MOD) : (operator_mode > OP_SHR);
        div_zero = (mode == MODE_MULDIV) && (number2 == '0) &&
                   ((operator_mode == OP_DIV) || (operator_mode == OP_MOD));
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        num_d    = num_q;
        err_d    = err_q;
        eq_d     = eq_q;
        md_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = operator_mode;
                    eq_d = (number1 == number2);
                    if (mode == MODE_LOGIC || illegal) begin
                        num_d   = illegal ? '0 : logic_res;
                        err_d   = illegal;
                        state_d = DONE;
                    end else if (div_zero) begin
                        num_d   = (operator_mode == OP_DIV) ? OUT_W'({W{1'b1}}) : OUT_W'(number1);
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        md_start = 1'b1;
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                if (md_done) begin
                    if (op_q == OP_MUL) begin
                        num_d = OUT_W'(md_product);
                    end else if (op_q == OP_DIV) begin
                        num_d = OUT_W'(md_quotient);
                    end else begin
                        num_d = OUT_W'(md_remainder);
                    end
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
            eq_q    <= 1'b0;
            bal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            num_q   <= num_d;
            err_q   <= err_d;
            eq_q    <= eq_d;
            bal_q   <= ^num_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign output_num  = num_q;
    assign balanceBit  = bal_q;
    assign equalityBit = eq_q;
    assign error       = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed and randomized bench for alu_seq_core against an arithmetic reference model.
module tb_alu_seq_core;
    localparam int unsigned W     = 5;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned SH_W  = $clog2(W);
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

    logic             Clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             mode = 1'b0;
    logic [W-1:0]     number1 = '0;
    logic [W-1:0]     number2 = '0;
    logic [5:0]       operator_mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] output_num;
    logic             balanceBit;
    logic             equalityBit;
    logic             error;
    logic             busy;

    int n_pass  = 0;
    int n_total = 0;

    alu_seq_core #(.W(W), .OUT_W(OUT_W)) dut (
        .Clk           (Clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mode          (mode),
        .number1       (number1),
        .number2       (number2),
        .operator_mode (operator_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .output_num    (output_num),
        .balanceBit    (balanceBit),
        .equalityBit   (equalityBit),
        .error         (error),
        .busy          (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model(input logic m, input logic [5:0] op, input logic [W-1:0] a_v,
                                  input logic [W-1:0] b_v, output longint unsigned num,
                                  output bit err);
        longint unsigned a  = 64'(a_v);
        longint unsigned b  = 64'(b_v);
        int unsigned     sh = int'(b % (64'd1 << SH_W));
        num = 0;
        err = 0;
        if (m == 1'b0) begin
            case (op)
                6'd0:    num = a & b;
                6'd1:    num = a | b;
                6'd2:    num = a ^ b;
                6'd3:    num = ~a & MASK;
                6'd4:    num = a + b;
                6'd5:    num = ((a < b) ? (64'd1 << W) : 64'd0) + ((a - b) & MASK);
                6'd6:    num = (a << sh) & MASK;
                6'd7:    num = a >> sh;
                default: err = 1;
            endcase
        end else begin
            case (op)
                6'd0: num = a * b;
                6'd1: begin
                    if (b == 0) begin num = MASK; err = 1; end
                    else num = a / b;
                end
                6'd2: begin
                    if (b == 0) begin num = a; err = 1; end
                    else num = a % b;
                end
                default: err = 1;
            endcase
        end
    endfunction

    // One full transaction; hold = cycles the consumer stalls once the result is valid.
    task automatic run(input logic m, input logic [5:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
        longint unsigned en;
        bit              ee;
        int              edges;
        logic [OUT_W-1:0] snap;
        model(m, op, a, b, en, ee);
        @(negedge Clk);
        check("in_ready_before", 64'(in_ready), 64'd1);
        in_valid = 1'b1; mode = m; operator_mode = op; number1 = a; number2 = b;
        out_ready = (hold == 0);
        @(negedge Clk);
        in_valid = 1'b0;
        number1 = W'($urandom); number2 = W'($urandom); mode = 1'($urandom);
        edges = 1;
        while (!out_valid && edges < 4 * W + 10) begin
            @(negedge Clk);
            edges++;
        end
        check("latency", 64'(edges), (m == 1'b0 || ee) ? 64'd1 : 64'(W + 1));
        check("output_num", 64'(output_num), en);
        check("error", 64'(error), 64'(ee));
        check("balanceBit", 64'(balanceBit), 64'($countones(en) & 1));
        check("equalityBit", 64'(equalityBit), 64'(a == b));
        snap = output_num;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge Clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_num", 64'(output_num), 64'(snap));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        check("consumed_valid", 64'(out_valid), 64'd0);
        check("consumed_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_output_num", 64'(output_num), 64'd0);
        check("rst_balance", 64'(balanceBit), 64'd0);
        check("rst_equality", 64'(equalityBit), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);

        run(1'b0, 6'd4, 5'd23, 5'd14, 0);
        run(1'b1, 6'd0, 5'd31, 5'd31, 0);
        run(1'b1, 6'd1, 5'd29, 5'd4, 0);
        run(1'b1, 6'd2, 5'd29, 5'd4, 0);
        run(1'b1, 6'd1, 5'd9, 5'd0, 0);
        run(1'b1, 6'd2, 5'd9, 5'd0, 1);
        run(1'b0, 6'd4, 5'd23, 5'd14, 3);
        run(1'b0, 6'd63, 5'd12, 5'd12, 0);
        run(1'b0, 6'd5, 5'd3, 5'd9, 0);
        run(1'b0, 6'd6, 5'd7, 5'd6, 0);

        // reset on the third CALC cycle of a multiply abandons it
        @(negedge Clk);
        in_valid = 1'b1; mode = 1'b1; operator_mode = 6'd0; number1 = 5'd31; number2 = 5'd30;
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (2) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        check("midcalc_out_valid", 64'(out_valid), 64'd0);
        check("midcalc_output_num", 64'(output_num), 64'd0);
        check("midcalc_in_ready", 64'(in_ready), 64'd1);
        run(1'b0, 6'd4, 5'd1, 5'd1, 0);

        for (int i = 0; i < 150; i++) begin
            logic       m;
            logic [5:0] op;
            logic [W-1:0] a, b;
            m  = 1'($urandom);
            op = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 9));
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run(m, op, a, b, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
